// File: rtl/decode_issue_ctrl_pkg.sv
// Shared opcode constants and enums for the decode issue controller and immediate decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional feature macro used by the design: DECODE_ILLEGAL_TRAP_EN.
package decode_pkg;

  // Base RV32 major opcodes (instr[6:0]) that the classifier recognises.
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  // Immediate-format select consumed by the immediate generator.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_t;

  // Occupancy of the output register plus skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side and execute-side handshake bundle of the decode issue controller.
// Latency: n/a (wires only); slave = controller, master = fetch/execute environment.
// Backpressure: in_ready/out_ready; out_illegal exists only with DECODE_ILLEGAL_TRAP_EN.
interface decode_issue_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_instr;
  logic [ADDR_WIDTH-1:0] in_pc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [2:0]            out_imm_src;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                  out_illegal;
`endif

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm_src
`ifdef DECODE_ILLEGAL_TRAP_EN
    , input out_illegal
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm_src
`ifdef DECODE_ILLEGAL_TRAP_EN
    , output out_illegal
`endif
  );
endinterface

// File: rtl/decode_issue_ctrl_imm_src_decoder.sv
// Combinational opcode classifier: opcode -> immediate-format select (+ illegal flag).
// Latency: 0 cycles, purely combinational.
// Backpressure: none. The illegal output exists only with DECODE_ILLEGAL_TRAP_EN.
module imm_src_decoder
  import decode_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_src_t   imm_src
`ifdef DECODE_ILLEGAL_TRAP_EN
  , output logic     illegal
`endif
);

  // R-type and unknown opcodes carry no immediate; I is the harmless default.
  always_comb begin
    imm_src = IMM_I;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal = 1'b0;
`endif
    case (opcode)
      OP_IMM, LOAD, JALR, SYSTEM, OP: imm_src = IMM_I;
      STORE:                          imm_src = IMM_S;
      BRANCH:                         imm_src = IMM_B;
      LUI, AUIPC:                     imm_src = IMM_U;
      JAL:                            imm_src = IMM_J;
      default: begin
        imm_src = IMM_I;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: 2-entry skid buffer between fetch and ID/EX, classifies at capture.
// Latency: accepted in cycle N -> on out_* in N+1; 1 instr/cycle with out_ready held high.
// Backpressure: in_ready is a flop (low when skid full / illegal held with DECODE_ILLEGAL_TRAP_EN).
module decode_issue_ctrl
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  decode_issue_ctrl_if.slave bus
);

  issue_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d, skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
  imm_src_t              out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  imm_src_t              in_imm;
  logic                  in_ready_q, in_ready_d;
  logic                  in_fire, out_fire, out_valid;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                  in_ill, out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
`endif

  imm_src_decoder u_imm_src_decoder (
    .opcode  (bus.in_instr[6:0]),
    .imm_src (in_imm)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .illegal (in_ill)
`endif
  );

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  // Next occupancy and register contents; flush wins over any fire in the same cycle.
  always_comb begin
    state_d      = state_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_imm_d    = out_imm_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_imm_d   = skid_imm_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    out_ill_d    = out_ill_q;
    skid_ill_d   = skid_ill_q;
`endif
    if (bus.flush) begin
      state_d      = EMPTY;
      out_instr_d  = '0;
      out_pc_d     = '0;
      out_imm_d    = IMM_I;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      skid_imm_d   = IMM_I;
`ifdef DECODE_ILLEGAL_TRAP_EN
      out_ill_d    = 1'b0;
      skid_ill_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            out_instr_d = bus.in_instr;
            out_pc_d    = bus.in_pc;
            out_imm_d   = in_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
            out_ill_d   = in_ill;
`endif
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_instr_d = bus.in_instr;
            out_pc_d    = bus.in_pc;
            out_imm_d   = in_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
            out_ill_d   = in_ill;
`endif
          end else if (in_fire) begin
            state_d      = TWO;
            skid_instr_d = bus.in_instr;
            skid_pc_d    = bus.in_pc;
            skid_imm_d   = in_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
            skid_ill_d   = in_ill;
`endif
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d     = ONE;
            out_instr_d = skid_instr_q;
            out_pc_d    = skid_pc_q;
            out_imm_d   = skid_imm_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
            out_ill_d   = skid_ill_q;
`endif
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is precomputed for next cycle so it never depends on out_ready combinationally.
    in_ready_d = (state_d != TWO);
`ifdef DECODE_ILLEGAL_TRAP_EN
    // A held trap must be the youngest instruction, so stop accepting until it leaves.
    if (((state_d != EMPTY) && out_ill_d) || ((state_d == TWO) && skid_ill_d)) begin
      in_ready_d = 1'b0;
    end
`endif
  end

  // State and data registers; reset drops everything and holds off fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      in_ready_q   <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      out_imm_q    <= IMM_I;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_imm_q   <= IMM_I;
`ifdef DECODE_ILLEGAL_TRAP_EN
      out_ill_q    <= 1'b0;
      skid_ill_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      out_imm_q    <= out_imm_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_imm_q   <= skid_imm_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
      out_ill_q    <= out_ill_d;
      skid_ill_q   <= skid_ill_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm_src = out_imm_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.out_illegal = out_ill_q;
`endif

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Decode-stage issue controller between fetch and the ID/EX register. It accepts instructions from fetch over a valid/ready handshake and classifies each opcode into the 3-bit immediate-format select used by the immediate generator. It holds the instruction, PC and format select in a 2-entry skid buffer, so the upstream ready is driven from a register. It also handles back-pressure from execute and pipeline flushes from branch resolution.

Parameters:
DATA_WIDTH, 32, instruction and PC width
ADDR_WIDTH, 32, PC width (must be less than or equal to DATA_WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  fetch presents an instruction
in_ready  output  1  controller can accept; registered, never combinational from out_ready
in_instr  input  DATA_WIDTH  fetched instruction word
in_pc  input  ADDR_WIDTH  PC of in_instr
flush  input  1  discard all held and incoming instructions (branch/jump taken)
out_valid  output  1  held instruction available to execute
out_ready  input  1  execute accepts this cycle
out_instr  output  DATA_WIDTH  instruction to immediate generator and ID/EX
out_pc  output  ADDR_WIDTH  PC of out_instr
out_imm_src  output  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J
out_illegal  output  1  unrecognised opcode (present only with the optional feature)

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_* fields stay stable while out_valid=1 and out_ready=0.
- State machine, 3 states (registered):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, skid empty, in_ready=1.
  - TWO: out_valid=1, skid full, in_ready=0.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE; output register loads the input.
  - ONE: in_fire & out_fire -> ONE; output register replaced by the input.
  - ONE: in_fire & !out_fire -> TWO; skid register loads the input.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: neither -> ONE.
  - TWO: out_fire -> ONE; output register loads from skid. No input accepted in TWO.
- Order is preserved: skid contents always issue after the output register.
- Latency: an instruction accepted in cycle N is visible on out_* in cycle N+1 (EMPTY/ONE path). Throughput is one instruction per cycle when out_ready is held high.
- Classification is done at capture time and stored alongside the instruction:
  - 0010011, 0000011, 1100111, 1110011 -> 000 (I)
  - 0100011 -> 001 (S)
  - 1100011 -> 010 (B)
  - 0110111, 0010111 -> 011 (U)
  - 1101111 -> 100 (J)
  - 0110011 (R) -> 000
  - any other opcode -> 000
- flush (synchronous):
  - Next state is EMPTY; both registers are invalidated.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by execute.
- Reset: rst_n=0 at a clock edge takes priority over flush.
  - State EMPTY; all out_* and skid data cleared to 0; out_valid=0.
  - in_ready=0 during reset, 1 in the first cycle after release.
- Reset asserted mid-operation drops held instructions with no partial issue.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - out_illegal port exists; it is set for an opcode outside the list above and stored per entry.
  - An illegal entry is still issued.
  - A further in_fire is blocked (in_ready=0) until the illegal entry issues or a flush arrives, so no younger instruction follows a trap.
- When undefined:
  - No out_illegal port.
  - Illegal opcodes map to 000 and flow normally.

Decomposition:
- Shared package decode_pkg:
  - opcode localparams (OP_IMM, LOAD, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL, OP).
  - imm_src_t enum, 3 bits, values I/S/B/U/J as above.
  - issue_state_t enum {EMPTY, ONE, TWO}.
- One sub-module imm_src_decoder: combinational, opcode -> imm_src (and illegal bit). The same sub-module is reused by the control unit.

Test Plan:
- Reset then stream with out_ready=1:
  - Stimulus: 0x00500093, 0x00112223, 0x00000463, 0x12345037, 0x008000EF.
  - Required: out_imm_src 000, 001, 010, 011, 100 on consecutive cycles, each one cycle after acceptance, in_ready=1 throughout.
- Back-pressure:
  - Stimulus: out_ready=0 while two instructions (pc 0x0, 0x4) arrive.
  - Required: state TWO, in_ready=0, out_pc=0x0 held stable; after out_ready=1, issue order is pc 0x0 then 0x4.
- Flush in TWO with in_valid=1:
  - Required: next cycle out_valid=0, in_ready=1; no held or incoming PC ever appears on out_*.
- Reset asserted while in ONE:
  - Required: out_valid=0 and out_instr=0 after the edge; in_ready=0 while rst_n=0.
- With DECODE_ILLEGAL_TRAP_EN:
  - Stimulus: 0x0000007F followed by 0x00500093.
  - Required: out_illegal=1 and out_imm_src=000; the second instruction is not accepted until the first issues.
